// File: rtl/shift_right_serializer_pkg.sv
// rtl/shift_right_serializer_pkg.sv - shared state type and counter-width helper for serializers
package shift_right_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_right_stage.sv
// rtl/shift_right_stage.sv - WIDTH-bit register with load / zero-fill right shift / hold
module shift_right_stage #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load has priority so a back-to-back word replaces the final shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_right_serializer.sv
// rtl/shift_right_serializer.sv - parallel-load, LSB-first serializer with valid/ready load port
module shift_right_serializer
  import shift_right_serializer_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic [WIDTH-1:0] q
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             in_shift;
  logic             cnt_zero;
  logic             load_fire;
  logic             shift_fire;

  assign in_shift   = (state == SHIFT);
  assign cnt_zero   = (cnt == '0);
  assign ser_valid  = in_shift;
  assign ser_last   = in_shift & cnt_zero;
  assign ser_out    = q[0];
  assign load_ready = ~rst & (~in_shift | (ser_last & shift_en));
  assign load_fire  = load_valid & load_ready;
  assign shift_fire = in_shift & shift_en;

  // On the final bit without a new word, the shift clears the only remaining bit.
  shift_right_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .clk  (clk),
    .rst  (rst),
    .load (load_fire),
    .shift(shift_fire),
    .d    (load_data),
    .q    (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (load_fire) begin
      state_d = SHIFT;
      cnt_d   = LAST_IDX;
    end else if (shift_fire) begin
      if (cnt_zero) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_right_serializer.sv
// tb/tb_shift_right_serializer.sv - scoreboard bench for shift_right_serializer (WIDTH 3 and 8)
module tb_shift_right_serializer;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       lv3, lr3, se3, so3, sv3, sl3;
  logic [2:0] ld3, q3;
  logic       lv8, lr8, se8, so8, sv8, sl8;
  logic [7:0] ld8, q8;

  int checks   = 0;
  int failures = 0;

  // each entry: {expected ser_out, expected ser_last}
  logic [1:0] exp3[$];
  logic [1:0] exp8[$];
  logic [1:0] e3, e8;

  shift_right_serializer #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .load_valid(lv3), .load_data(ld3), .load_ready(lr3),
    .shift_en(se3), .ser_out(so3), .ser_valid(sv3), .ser_last(sl3), .q(q3)
  );

  shift_right_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8), .load_ready(lr8),
    .shift_en(se8), .ser_out(so8), .ser_valid(sv8), .ser_last(sl8), .q(q8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && sv3 === 1'b1 && se3 === 1'b1) begin
      if (exp3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w3_unexpected_bit: got ser_out=%0b with empty scoreboard", so3);
      end else begin
        e3 = exp3.pop_front();
        chk("w3_ser_out", 32'(so3), 32'(e3[1]));
        chk("w3_ser_last", 32'(sl3), 32'(e3[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && sv8 === 1'b1 && se8 === 1'b1) begin
      if (exp8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w8_unexpected_bit: got ser_out=%0b with empty scoreboard", so8);
      end else begin
        e8 = exp8.pop_front();
        chk("w8_ser_out", 32'(so8), 32'(e8[1]));
        chk("w8_ser_last", 32'(sl8), 32'(e8[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic b0, input logic b1, input logic b2);
    exp3.push_back({b0, 1'b0});
    exp3.push_back({b1, 1'b0});
    exp3.push_back({b2, 1'b1});
  endtask

  task automatic load3(input logic [2:0] d);
    bit ok;
    ok  = 1'b0;
    lv3 = 1'b1;
    ld3 = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lr3 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL load3_timeout: got load_ready=%0b expected 1", lr3);
    end
    step();
    lv3 = 1'b0;
  endtask

  task automatic load8(input logic [7:0] d);
    bit ok;
    ok  = 1'b0;
    lv8 = 1'b1;
    ld8 = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lr8 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL load8_timeout: got load_ready=%0b expected 1", lr8);
    end
    step();
    lv8 = 1'b0;
  endtask

  task automatic drain3();
    for (int i = 0; i < 50; i++) begin
      if (exp3.size() == 0) break;
      @(negedge clk);
    end
    chk("w3_drain", 32'(exp3.size()), 0);
    step();
  endtask

  task automatic drain8();
    for (int i = 0; i < 50; i++) begin
      if (exp8.size() == 0) break;
      @(negedge clk);
    end
    chk("w8_drain", 32'(exp8.size()), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int gaps;
    logic r;

    rst = 1'b1;
    lv3 = 1'b0; ld3 = '0; se3 = 1'b0;
    lv8 = 1'b0; ld8 = '0; se8 = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_q3", 32'(q3), 0);
    chk("rst_ser_valid", 32'(sv3), 0);
    chk("rst_ser_last", 32'(sl3), 0);
    chk("rst_ser_out", 32'(so3), 0);
    chk("rst_load_ready", 32'(lr3), 0);
    chk("rst_q8", 32'(q8), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_load_ready", 32'(lr3), 1);
    chk("post_rst_ser_valid", 32'(sv3), 0);

    // 101 streamed with continuous shift_en
    step();
    se3 = 1'b1;
    push3(1'b1, 1'b0, 1'b1);
    load3(3'b101);
    @(negedge clk); chk("t1_q_0", 32'(q3), 32'h5);
    @(negedge clk); chk("t1_q_1", 32'(q3), 32'h2);
    @(negedge clk); chk("t1_q_2", 32'(q3), 32'h1);
    @(negedge clk);
    chk("t1_q_3", 32'(q3), 0);
    chk("t1_idle_valid", 32'(sv3), 0);
    chk("t1_idle_ready", 32'(lr3), 1);

    // 110 with a 5-cycle stall on the first bit
    step();
    se3 = 1'b0;
    push3(1'b0, 1'b1, 1'b1);
    load3(3'b110);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_out", 32'(so3), 0);
      chk("t2_stall_valid", 32'(sv3), 1);
      chk("t2_stall_q", 32'(q3), 32'h6);
    end
    step();
    se3 = 1'b1;
    drain3();

    // back-to-back 011 then 100
    push3(1'b1, 1'b1, 1'b0);
    push3(1'b0, 1'b0, 1'b1);
    lv3 = 1'b1;
    ld3 = 3'b011;
    step();
    ld3 = 3'b100;
    pulses = 0;
    gaps   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5 && lr3 === 1'b1) pulses++;
      if (sv3 !== 1'b1) gaps++;
      r = lr3;
      step();
      if (r === 1'b1) lv3 = 1'b0;
    end
    chk("t3_ready_pulses", 32'(pulses), 1);
    chk("t3_valid_gaps", 32'(gaps), 0);
    drain3();

    // load offered on the 2nd bit must be ignored
    push3(1'b0, 1'b1, 1'b0);
    load3(3'b010);
    @(negedge clk);
    step();
    lv3 = 1'b1;
    ld3 = 3'b111;
    @(negedge clk);
    chk("t4_ready_midword", 32'(lr3), 0);
    step();
    lv3 = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t4_idle_valid", 32'(sv3), 0);
    chk("t4_idle_q", 32'(q3), 0);
    step();

    // asynchronous reset mid-word
    exp3.push_back({1'b1, 1'b0});
    load3(3'b101);
    @(negedge clk);
    @(posedge clk);
    #1 se3 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t5_async_q", 32'(q3), 0);
    chk("t5_async_valid", 32'(sv3), 0);
    chk("t5_async_ready", 32'(lr3), 0);
    chk("t5_async_out", 32'(so3), 0);
    step();
    rst = 1'b0;
    se3 = 1'b1;
    push3(1'b0, 1'b1, 1'b1);
    load3(3'b110);
    drain3();

    // WIDTH=8, 0xA5
    se8 = 1'b1;
    exp8.push_back({1'b1, 1'b0});
    exp8.push_back({1'b0, 1'b0});
    exp8.push_back({1'b1, 1'b0});
    exp8.push_back({1'b0, 1'b0});
    exp8.push_back({1'b0, 1'b0});
    exp8.push_back({1'b1, 1'b0});
    exp8.push_back({1'b0, 1'b0});
    exp8.push_back({1'b1, 1'b1});
    load8(8'hA5);
    drain8();
    @(negedge clk);
    chk("t6_idle_valid", 32'(sv8), 0);
    chk("t6_idle_q", 32'(q8), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
